wb_write_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline write-back slot, whose immediate/ALU value is already selected by the write-back stage;
  - a multi-cycle unit such as the memory load return or the interrupt/pop sequencer.
- Pipeline has priority. A one-entry skid buffer holds a displaced pipeline write, and a starvation counter guarantees the multi-cycle unit a grant.
- Sits between the write-back stage and the register file.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_skid_buf.sv | 34 +++
 rtl/wb_write_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the write-back arbiter slice.
// Holds width defaults, arbiter states and the write request bundle.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;

  typedef enum logic {
    P_PRIO  = 1'b0,
    M_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic wb_req_t mk_req(
    input logic                 v,
    input logic [WB_ADDR_W-1:0] a,
    input logic [WB_DATA_W-1:0] d
  );
    wb_req_t r;
    r.valid = v;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: one-entry holding register for a displaced pipeline write.
// A full entry is what freezes the pipeline (stall_o).
module wb_skid_buf
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    drain,
  input  logic    flush,
  input  wb_req_t d,
  output wb_req_t q,
  output logic    valid,
  output logic    stall_o
);

  wb_req_t ent_q;

  // load beats drain, so drain+load replaces the entry and stays full
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_q <= '0;
    end else if (load) begin
      ent_q <= mk_req(1'b1, d.addr, d.data);
    end else if (drain) begin
      ent_q.valid <= 1'b0;
    end
  end

  assign q       = ent_q;
  assign valid   = ent_q.valid;
  assign stall_o = ent_q.valid;

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: pipeline-priority arbiter for the RF write port.
// Optional WB_FWD_EN exposes the skid entry on fwd_* for decode.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              stall_o,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  wb_req_t p_req;
  wb_req_t m_req;
  wb_req_t s_req;
  wb_req_t win;
  wb_req_t rf_q;

  logic s_valid;
  logic p_live;
  logic sk_load;
  logic sk_drain;

  assign p_req  = mk_req(p_valid, p_addr, p_data);
  assign m_req  = mk_req(m_valid, m_addr, m_data);
  assign p_live = p_valid && !stall_o;

  wb_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (sk_load),
    .drain   (sk_drain),
    .flush   (1'b0),
    .d       (p_req),
    .q       (s_req),
    .valid   (s_valid),
    .stall_o (stall_o)
  );

  // pick this cycle's winner, steer the skid and track starvation
  always_comb begin
    state_d  = P_PRIO;
    cnt_d    = '0;
    win      = '0;
    m_ready  = 1'b0;
    sk_load  = 1'b0;
    sk_drain = 1'b0;
    unique case (state_q)
      P_PRIO: begin
        if (s_valid) begin
          win      = s_req;
          sk_drain = 1'b1;
          sk_load  = p_live;
        end else if (p_live) begin
          win = p_req;
        end else if (m_valid) begin
          win     = m_req;
          m_ready = 1'b1;
        end
        if (m_valid && !m_ready) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_MAX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (m_valid && (cnt_d == CNT_MAX)) begin
          state_d = M_FORCE;
        end
      end
      M_FORCE: begin
        m_ready = 1'b1;
        if (m_valid) begin
          win = m_req;
        end
        sk_load = p_live && !s_valid;
      end
      default: begin
        state_d = P_PRIO;
      end
    endcase
  end

  // state, starvation count and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_PRIO;
      cnt_q   <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_q    <= win;
    end
  end

  assign rf_we    = rf_q.valid;
  assign rf_waddr = rf_q.addr;
  assign rf_wdata = rf_q.data;

`ifdef WB_FWD_EN
  assign fwd_valid = s_valid;
  assign fwd_addr  = s_req.addr;
  assign fwd_data  = s_req.data;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed plus random check against a queue model.
// Define WB_FWD_EN to also check the fwd_* outputs.
module tb_wb_write_arbiter;

  localparam int STARVE = 4;

  typedef struct packed {
    logic        v;
    logic [2:0]  a;
    logic [15:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_valid = 1'b0;
  logic [2:0]  p_addr = '0;
  logic [15:0] p_data = '0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_ready;
  logic        stall_o;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
`endif

  int total  = 0;
  int passed = 0;

  req_t skq[$];
  int   deny    = 0;
  bit   forcing = 1'b0;

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (3),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .stall_o   (stall_o),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
`ifdef WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic reset_cycle(input bit pv, input logic [2:0] pa,
                             input logic [15:0] pd);
    @(negedge clk);
    rst     = 1'b1;
    p_valid = pv;
    p_addr  = pa;
    p_data  = pd;
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    skq.delete();
    deny    = 0;
    forcing = 1'b0;
    chk("rst_we", 32'(rf_we), 32'(0));
    chk("rst_stall", 32'(stall_o), 32'(0));
  endtask

  task automatic cycle(input bit pv, input logic [2:0] pa,
                       input logic [15:0] pd, input bit mv,
                       input logic [2:0] ma, input logic [15:0] md,
                       output bit p_acc, output bit m_acc);
    req_t win;
    req_t pr;
    req_t mq;
    bit   exp_stall;
    bit   p_live;
    bit   mr;
    @(negedge clk);
    rst     = 1'b0;
    p_valid = pv;
    p_addr  = pa;
    p_data  = pd;
    m_valid = mv;
    m_addr  = ma;
    m_data  = md;
    #1;
    exp_stall = skq.size() != 0;
    p_live    = pv && !exp_stall;
    pr        = '{v: 1'b1, a: pa, d: pd};
    mq        = '{v: 1'b1, a: ma, d: md};
    chk("stall", 32'(stall_o), 32'(exp_stall));
`ifdef WB_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(exp_stall));
    if (exp_stall) begin
      chk("fwd_addr", 32'(fwd_addr), 32'(skq[0].a));
      chk("fwd_data", 32'(fwd_data), 32'(skq[0].d));
    end
`endif
    win = '0;
    mr  = 1'b0;
    if (forcing) begin
      mr = 1'b1;
      if (mv) win = mq;
      if (p_live) skq.push_back(pr);
      deny    = 0;
      forcing = 1'b0;
    end else begin
      if (skq.size() != 0) begin
        win = skq.pop_front();
        if (p_live) skq.push_back(pr);
      end else if (p_live) begin
        win = pr;
      end else if (mv) begin
        win = mq;
        mr  = 1'b1;
      end
      if (mv && !mr) deny = (deny < STARVE) ? deny + 1 : STARVE;
      else deny = 0;
      forcing = mv && (deny == STARVE);
    end
    chk("m_ready", 32'(m_ready), 32'(mr));
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we), 32'(win.v));
    if (win.v) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(win.a));
      chk("rf_wdata", 32'(rf_wdata), 32'(win.d));
    end
    p_acc = p_live;
    m_acc = mv && mr;
  endtask

  bit          pa_c;
  bit          ma_c;
  bit          have_p;
  bit          have_m;
  logic [2:0]  qpa;
  logic [15:0] qpd;
  logic [2:0]  qma;
  logic [15:0] qmd;
  bit          dpv;
  bit          dmv;
  logic [2:0]  dpa;
  logic [15:0] dpd;

  initial begin
    // reset held with a live pipeline request
    for (int i = 0; i < 3; i++) reset_cycle(1'b1, 3'd2, 16'd150);
    cycle(1'b1, 3'd2, 16'd150, 1'b0, 3'd0, 16'd0, pa_c, ma_c);
    chk("t1_we", 32'(rf_we), 32'(1));
    chk("t1_addr", 32'(rf_waddr), 32'(2));
    chk("t1_data", 32'(rf_wdata), 32'(150));

    // pipeline only, back to back
    cycle(1'b1, 3'd1, 16'd150, 1'b0, 3'd0, 16'd0, pa_c, ma_c);
    chk("t2_a", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd1, 16'd150}));
    cycle(1'b1, 3'd3, 16'd120, 1'b0, 3'd0, 16'd0, pa_c, ma_c);
    chk("t2_b", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd3, 16'd120}));
    chk("t2_stall", 32'(stall_o), 32'(0));

    // multi-cycle unit alone
    cycle(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h00AA, pa_c, ma_c);
    chk("t3_acc", 32'(ma_c), 32'(1));
    chk("t3_w", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd5, 16'h00AA}));

    // starvation: four denials, then a forced write
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 3'(k), 16'h0100 + 16'(k), 1'b1, 3'd6, 16'h1234, pa_c, ma_c);
      chk("t4_p", 32'({rf_we, rf_wdata}), 32'({1'b1, 16'h0100 + 16'(k)}));
      chk("t4_deny", 32'(ma_c), 32'(0));
    end
    cycle(1'b1, 3'd4, 16'h0F0F, 1'b1, 3'd6, 16'h1234, pa_c, ma_c);
    chk("t4_force", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd6, 16'h1234}));
    chk("t4_macc", 32'(ma_c), 32'(1));
    chk("t5_stall_hi", 32'(stall_o), 32'(1));
`ifdef WB_FWD_EN
    chk("t6_fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'({1'b1, 3'd4, 16'h0F0F}));
`endif
    // changed data while stalled is not sampled
    cycle(1'b1, 3'd5, 16'hDEAD, 1'b0, 3'd0, 16'd0, pa_c, ma_c);
    chk("t5_drain", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd4, 16'h0F0F}));
    chk("t5_pacc", 32'(pa_c), 32'(0));
    chk("t5_stall_lo", 32'(stall_o), 32'(0));
    cycle(1'b1, 3'd5, 16'h0105, 1'b0, 3'd0, 16'd0, pa_c, ma_c);
    chk("t5_next", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 3'd5, 16'h0105}));

    // random traffic with occasional mid-run reset
    have_p = 1'b0;
    have_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_cycle(1'b1, 3'($urandom), 16'($urandom));
        continue;
      end
      if (!have_p && $urandom_range(0, 3) != 0) begin
        have_p = 1'b1;
        qpa    = 3'($urandom);
        qpd    = 16'($urandom);
      end
      if (!have_m && $urandom_range(0, 4) == 0) begin
        have_m = 1'b1;
        qma    = 3'($urandom);
        qmd    = 16'($urandom);
      end
      if (skq.size() != 0) begin
        dpv = 1'($urandom);
        dpa = 3'($urandom);
        dpd = 16'($urandom);
      end else begin
        dpv = have_p;
        dpa = qpa;
        dpd = qpd;
      end
      dmv = have_m && !(forcing && $urandom_range(0, 7) == 0);
      cycle(dpv, dpa, dpd, dmv, qma, qmd, pa_c, ma_c);
      if (pa_c) have_p = 1'b0;
      if (ma_c) have_m = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
